z80_shadow_mem_arbiter: RTL

- Arbitrates one single-port synchronous block RAM (the ROM shadow/overlay memory) between two requesters.
- Requester 1: the Z80 bus side, driven by the already-synchronised and edge-captured RD/WR strobes and address. It has absolute priority and bounded latency.
- Requester 2: the SPI host loader, which uses a req/ack handshake and takes the leftover slots.
- Sits between the Z80 address decoder and the RAM primitive; runs entirely in the HFOSC domain.

---
 rtl/z80_mem_pkg.sv | 15 +
 rtl/z80_req_slot.sv | 50 +++++
 rtl/z80_shadow_mem_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/z80_mem_pkg.sv
// Shared definitions for the Z80 shadow-memory arbiter: FSM state encoding
// and the default address width of the 16 KiB ROM window.
package z80_mem_pkg;

    localparam int AW_DEFAULT = 14;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        Z_ISSUE = 3'd1,
        Z_CAP   = 3'd2,
        S_ISSUE = 3'd3,
        S_CAP   = 3'd4
    } arb_state_t;

endpackage

// File: rtl/z80_req_slot.sv
// One-entry capture register for Z80 bus requests. A request arriving while
// the slot still holds an unserved one is dropped and flagged as an overrun.
// A request arriving in the same cycle the slot is freed takes its place.
import z80_mem_pkg::*;

module z80_req_slot #(
    parameter int AW = AW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic          wp,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    input  logic          free,
    output logic          full,
    output logic          slot_we,
    output logic          slot_drop,
    output logic [AW-1:0] slot_addr,
    output logic [7:0]    slot_wdata,
    output logic          overrun
);

    // Capture / release the pending request and latch the sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            full       <= 1'b0;
            slot_we    <= 1'b0;
            slot_drop  <= 1'b0;
            slot_addr  <= '0;
            slot_wdata <= '0;
            overrun    <= 1'b0;
        end else begin
            if (req && (!full || free)) begin
                full       <= 1'b1;
                slot_we    <= we;
                // write-protected writes are accepted but only consumed
                slot_drop  <= we & wp;
                slot_addr  <= addr;
                slot_wdata <= wdata;
            end else if (free) begin
                full <= 1'b0;
            end
            if (req && full && !free)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/z80_shadow_mem_arbiter.sv
// Arbitrates the single-port shadow RAM between the Z80 bus (absolute
// priority, bounded latency) and the SPI loader (leftover slots, req/ack).
// All RAM-side outputs and requester responses are registered.
import z80_mem_pkg::*;

module z80_shadow_mem_arbiter #(
    parameter int         AW          = AW_DEFAULT,
    parameter logic [7:0] RESET_RDATA = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          z80_req,
    input  logic          z80_we,
    input  logic [AW-1:0] z80_addr,
    input  logic [7:0]    z80_wdata,
    input  logic          z80_wp,
    output logic [7:0]    z80_rdata,
    output logic          z80_rvalid,
    output logic          z80_overrun,
    input  logic          spi_req,
    input  logic          spi_we,
    input  logic [AW-1:0] spi_addr,
    input  logic [7:0]    spi_wdata,
    output logic          spi_ack,
    output logic [7:0]    spi_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    arb_state_t    state;
    logic          slot_full, slot_we, slot_drop, slot_free;
    logic [AW-1:0] slot_addr;
    logic [7:0]    slot_wdata;
    logic          pend_valid, pend_we, pend_drop;
    logic [AW-1:0] pend_addr;
    logic [7:0]    pend_wdata;

    z80_req_slot #(.AW(AW)) u_slot (
        .clk        (clk),
        .rst        (rst),
        .req        (z80_req),
        .we         (z80_we),
        .wp         (z80_wp),
        .addr       (z80_addr),
        .wdata      (z80_wdata),
        .free       (slot_free),
        .full       (slot_full),
        .slot_we    (slot_we),
        .slot_drop  (slot_drop),
        .slot_addr  (slot_addr),
        .slot_wdata (slot_wdata),
        .overrun    (z80_overrun)
    );

    // Pending Z80 access: the slot entry, or the request arriving right now so
    // an uncontended access reaches the RAM one cycle after z80_req.
    always_comb begin
        pend_valid = slot_full | z80_req;
        pend_we    = slot_full ? slot_we    : z80_we;
        pend_drop  = slot_full ? slot_drop  : (z80_we & z80_wp);
        pend_addr  = slot_full ? slot_addr  : z80_addr;
        pend_wdata = slot_full ? slot_wdata : z80_wdata;
        // the slot frees when its access can no longer be affected by a new one
        slot_free  = ((state == IDLE) && slot_full && slot_drop)
                   || ((state == Z_ISSUE) && mem_we)
                   || (state == Z_CAP);
    end

    // Arbiter FSM with registered RAM strobes and requester responses
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            spi_ack    <= 1'b0;
            spi_rdata  <= '0;
            z80_rvalid <= 1'b0;
            z80_rdata  <= RESET_RDATA;
        end else begin
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            spi_ack    <= 1'b0;
            z80_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (pend_valid) begin
                        // a protected write just drains from the slot
                        if (!pend_drop) begin
                            mem_en    <= 1'b1;
                            mem_we    <= pend_we;
                            mem_addr  <= pend_addr;
                            mem_wdata <= pend_wdata;
                            state     <= Z_ISSUE;
                        end
                    end else if (spi_req && !spi_ack) begin
                        mem_en    <= 1'b1;
                        mem_we    <= spi_we;
                        mem_addr  <= spi_addr;
                        mem_wdata <= spi_wdata;
                        state     <= S_ISSUE;
                    end
                end
                Z_ISSUE: state <= mem_we ? IDLE : Z_CAP;
                Z_CAP: begin
                    z80_rdata  <= mem_rdata;
                    z80_rvalid <= 1'b1;
                    state      <= IDLE;
                end
                S_ISSUE: begin
                    if (mem_we) begin
                        spi_ack <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        state <= S_CAP;
                    end
                end
                S_CAP: begin
                    spi_rdata <= mem_rdata;
                    spi_ack   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
